projectile_throw_ctl: RTL and testbench
=======================================

# projectile_throw_ctl

Turn-based controller that sequences one projectile flight at a time for the two players, cat and dog, and drives the position inputs of the projectile drawing stage. It accepts a throw request from the player whose turn it is, latches launch velocity, and integrates a ballistic trajectory once per video frame. It detects landing or leaving the screen, reports completion, and then hands the turn to the other player. It sits between player input/aim logic and the projectile draw modules in the throw path.

## Interface
- `X0_CAT`, default 60: cat launch x_pos; the cat throws toward increasing x_pos.
- `X0_DOG`, default 964: dog launch x_pos; the dog throws toward decreasing x_pos.
- `Y_GROUND`, default 100: launch and landing y_pos.
- `GRAVITY`, default 1: per-frame decrement of vertical velocity.
- `X_MAX`, default 994: largest legal x_pos.
- `clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `throw_cat` in 1: cat throw request (level or pulse).
- `throw_dog` in 1: dog throw request.
- `vx` in 6: unsigned horizontal speed, pixels/frame.
- `vy` in 6: unsigned initial upward speed, pixels/frame.
- `x_pos` out 12: projectile x, in the drawer's convention (distance from the right edge).
- `y_pos` out 12: projectile y (distance from the bottom edge).
- `active` out 1: flight in progress; the drawer renders only while this is high.
- `owner` out 1: thrower of the current or last flight; 0 = cat, 1 = dog.
- `turn` out 1: player allowed to throw next; 0 = cat.
- `done` out 1: one-cycle pulse at flight end.
- `wind` in 4: signed per-frame horizontal offset. Present only with `PROJ_WIND_EN`.

## Operation
- States: IDLE, FLY, LAND.
- IDLE:
  - A request from the `turn` player (`throw_cat` with turn=0, `throw_dog` with turn=1) is accepted.
  - On acceptance: latch vx, vy; set owner=turn; set x_pos to X0_CAT or X0_DOG; set y_pos=Y_GROUND; go to FLY.
  - Requests from the other player are ignored. If both requests are asserted together, only the turn holder's request counts.
- FLY, on each frame_tick:
  - x_next = x ± vx; `+` for the cat, `−` for the dog.
  - y_next = y + vys, then vys -= GRAVITY.
  - Landing: if y_next ≤ Y_GROUND, set y_pos=Y_GROUND, keep x_next, go to LAND.
  - Off-screen: if x_next > X_MAX or x_next < 0, clamp x to X_MAX or 0, keep y_next, go to LAND.
  - If both landing and off-screen hold on the same frame, apply both clamps.
  - All requests are ignored while in FLY.
- LAND (one cycle): done=1, active drops, turn toggles, go to IDLE. x_pos and y_pos hold their final values.
- Arithmetic:
  - vys is 8-bit signed, initialised to +vy.
  - Position math uses 13-bit signed internally; outputs are the low 12 bits after clamping.
  - vys saturates at −128.
- Reset values: IDLE, x_pos=X0_CAT, y_pos=Y_GROUND, active=0, owner=0, turn=0, done=0, vys=0. Reset mid-flight aborts the flight with no done pulse.

## Timing
- Accept cycle N: active=1 and x_pos/y_pos hold the launch values from N+1.
- Position outputs update on the cycle after the frame_tick.
- A frame_tick in the same cycle as acceptance is not integrated; the first move happens on the next frame_tick.
- done is asserted in the cycle after the landing frame_tick. turn reads toggled from the cycle after done.
- The earliest new acceptance is the cycle after done.

## Configuration
- `PROJ_WIND_EN` defined:
  - Port `wind` exists.
  - Each frame, the sign-extended wind is added to x_next after the vx step, for both owners.
  - The off-screen check uses the wind-adjusted value.
- `PROJ_WIND_EN` undefined: the port is absent and horizontal motion is vx only.

## Structure
- `throw_pkg`:
  - State enum.
  - Player encoding (CAT=0, DOG=1).
  - Default launch and ground constants.
  - Screen-limit constants, derived from `vga_pkg` HOR_PIXELS minus the projectile diameter (30).
- Sub-module `projectile_step`: combinational one-frame integrator.
  - Inputs: x, y, vys, vx, dir, wind.
  - Outputs: x_next, y_next, vys_next, landed, off_screen.
- `projectile_throw_ctl` contains the FSM, turn arbitration and output registers.

## Test plan
- Cat flight, vx=5, vy=4, GRAVITY=1:
  - y_pos per tick: 104, 107, 109, 110, 110, 109, 107, 104, 100.
  - done after tick 9; x_pos=105.
  - turn becomes 1.
- Turn enforcement:
  - throw_dog at turn=0 → no acceptance, active stays 0.
  - Then throw_cat → accepted, owner=0.
  - throw_cat during FLY → ignored.
- Simultaneous throw_cat and throw_dog with turn=1 → owner=1; x_pos starts at 964 and decreases by vx per tick.
- Off-screen: dog, vx=63, vy=63 → x clamps to 0 on tick 16, done pulses, y_pos > Y_GROUND.
- rst asserted on the 3rd tick of a flight → next cycle: IDLE, active=0, turn=0, x_pos=60, y_pos=100, no done pulse.
- With `PROJ_WIND_EN`: cat, vx=5, vy=4, wind=−2 → final x_pos=87; wind=+3 → x_pos=132.

Source files
------------

// File: rtl/throw_pkg.sv
// Shared types and constants for the projectile throw path.
package throw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    LAND
  } state_e;

  typedef enum logic {
    CAT = 1'b0,
    DOG = 1'b1
  } player_e;

  // Screen width mirrors the VGA timing; the projectile must stay fully visible.
  localparam int HOR_PIXELS    = 1024;
  localparam int PROJ_DIAMETER = 30;
  localparam int X_MAX_DEF     = HOR_PIXELS - PROJ_DIAMETER;

  localparam int X0_CAT_DEF   = 60;
  localparam int X0_DOG_DEF   = 964;
  localparam int Y_GROUND_DEF = 100;
  localparam int GRAVITY_DEF  = 1;

  localparam int POS_W = 13;

  function automatic logic signed [POS_W-1:0] toPos(input int v);
    return POS_W'(v);
  endfunction

endpackage

// File: rtl/projectile_step.sv
// Combinational one-frame ballistic integrator with landing and off-screen clamps.
module projectile_step
  import throw_pkg::*;
#(
  parameter int Y_GROUND = Y_GROUND_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int X_MAX    = X_MAX_DEF
) (
  input  logic signed [12:0] x,
  input  logic signed [12:0] y,
  input  logic signed [7:0]  vys,
  input  logic        [5:0]  vx,
  input  logic               dir,
  input  logic signed [3:0]  wind,
  output logic signed [12:0] x_next,
  output logic signed [12:0] y_next,
  output logic signed [7:0]  vys_next,
  output logic               landed,
  output logic               off_screen
);

  localparam logic signed [12:0] GroundS = toPos(Y_GROUND);
  localparam logic signed [12:0] XMaxS   = toPos(X_MAX);
  localparam logic signed [8:0]  GravS   = 9'(GRAVITY);
  localparam logic signed [8:0]  VysMin  = -9'sd128;

  logic signed [12:0] xStep;
  logic signed [12:0] xRaw;
  logic signed [12:0] yRaw;
  logic signed [8:0]  vysWide;

  // Wind is applied after the vx step so it pushes both players the same way.
  always_comb begin
    xStep   = dir ? (x - $signed({7'b0, vx})) : (x + $signed({7'b0, vx}));
    xRaw    = xStep + {{9{wind[3]}}, wind};
    yRaw    = y + {{5{vys[7]}}, vys};
    vysWide = {vys[7], vys} - GravS;

    landed     = (yRaw <= GroundS);
    off_screen = (xRaw > XMaxS) || (xRaw < 13'sd0);

    if (xRaw < 13'sd0) begin
      x_next = 13'sd0;
    end else if (xRaw > XMaxS) begin
      x_next = XMaxS;
    end else begin
      x_next = xRaw;
    end

    y_next   = landed ? GroundS : yRaw;
    vys_next = (vysWide < VysMin) ? -8'sd128 : vysWide[7:0];
  end

endmodule

// File: rtl/projectile_throw_ctl.sv
// Turn-based throw sequencer for cat and dog; drives the projectile drawer.
// Optional horizontal wind input is enabled with PROJ_WIND_EN.
module projectile_throw_ctl
  import throw_pkg::*;
#(
  parameter int X0_CAT   = X0_CAT_DEF,
  parameter int X0_DOG   = X0_DOG_DEF,
  parameter int Y_GROUND = Y_GROUND_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int X_MAX    = X_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        throw_cat,
  input  logic        throw_dog,
  input  logic [5:0]  vx,
  input  logic [5:0]  vy,
`ifdef PROJ_WIND_EN
  input  logic [3:0]  wind,
`endif
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        active,
  output logic        owner,
  output logic        turn,
  output logic        done
);

  state_e state_q, state_d;

  logic signed [12:0] x_q, x_d;
  logic signed [12:0] y_q, y_d;
  logic signed [7:0]  vys_q, vys_d;
  logic        [5:0]  vx_q, vx_d;
  logic               owner_q, owner_d;
  logic               turn_q, turn_d;

  logic signed [12:0] xNext;
  logic signed [12:0] yNext;
  logic signed [7:0]  vysNext;
  logic               landed;
  logic               offScreen;
  logic signed [3:0]  windS;
  logic               accept;

`ifdef PROJ_WIND_EN
  assign windS = wind;
`else
  assign windS = 4'sd0;
`endif

  projectile_step #(
    .Y_GROUND(Y_GROUND),
    .GRAVITY (GRAVITY),
    .X_MAX   (X_MAX)
  ) u_step (
    .x         (x_q),
    .y         (y_q),
    .vys       (vys_q),
    .vx        (vx_q),
    .dir       (owner_q),
    .wind      (windS),
    .x_next    (xNext),
    .y_next    (yNext),
    .vys_next  (vysNext),
    .landed    (landed),
    .off_screen(offScreen)
  );

  // Only the turn holder's request counts, so simultaneous requests resolve here.
  assign accept = (turn_q == DOG) ? throw_dog : throw_cat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= toPos(X0_CAT);
      y_q     <= toPos(Y_GROUND);
      vys_q   <= 8'sd0;
      vx_q    <= 6'd0;
      owner_q <= CAT;
      turn_q  <= CAT;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vys_q   <= vys_d;
      vx_q    <= vx_d;
      owner_q <= owner_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vys_d   = vys_q;
    vx_d    = vx_q;
    owner_d = owner_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = FLY;
          owner_d = turn_q;
          x_d     = (turn_q == DOG) ? toPos(X0_DOG) : toPos(X0_CAT);
          y_d     = toPos(Y_GROUND);
          vys_d   = $signed({2'b00, vy});
          vx_d    = vx;
        end
      end
      FLY: begin
        if (frame_tick) begin
          x_d   = xNext;
          y_d   = yNext;
          vys_d = vysNext;
          if (landed || offScreen) begin
            state_d = LAND;
          end
        end
      end
      LAND: begin
        state_d = IDLE;
        turn_d  = ~turn_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == FLY);
    done   = (state_q == LAND);
    owner  = owner_q;
    turn   = turn_q;
    x_pos  = x_q[11:0];
    y_pos  = y_q[11:0];
  end

endmodule

// File: tb/tb_projectile_throw_ctl.sv
// Directed bench for projectile_throw_ctl; wind cases run when PROJ_WIND_EN is defined.
module tb_projectile_throw_ctl;

  typedef struct {
    logic              tc;
    logic              td;
    logic              tk;
    logic [5:0]        vx;
    logic [5:0]        vy;
    logic signed [3:0] w;
    logic              act;
    int                x;
    int                y;
    logic              dn;
    logic              trn;
    logic              own;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        throw_cat;
  logic        throw_dog;
  logic [5:0]  vx;
  logic [5:0]  vy;
  logic [3:0]  wind;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic        active;
  logic        owner;
  logic        turn;
  logic        done;

  int passCount = 0;
  int checkCount = 0;

  vec_t vecs[24];

  always #5 clk = ~clk;

  projectile_throw_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .throw_cat (throw_cat),
    .throw_dog (throw_dog),
    .vx        (vx),
    .vy        (vy),
`ifdef PROJ_WIND_EN
    .wind      (wind),
`endif
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .active    (active),
    .owner     (owner),
    .turn      (turn),
    .done      (done)
  );

  function automatic vec_t mk(input int tc, input int td, input int tk, input int ivx, input int ivy,
                              input int iw, input int act, input int x, input int y, input int dn,
                              input int trn, input int own);
    vec_t v;
    v.tc  = tc[0];
    v.td  = td[0];
    v.tk  = tk[0];
    v.vx  = ivx[5:0];
    v.vy  = ivy[5:0];
    v.w   = iw[3:0];
    v.act = act[0];
    v.x   = x;
    v.y   = y;
    v.dn  = dn[0];
    v.trn = trn[0];
    v.own = own[0];
    return v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input vec_t v);
    throw_cat  = v.tc;
    throw_dog  = v.td;
    frame_tick = v.tk;
    vx         = v.vx;
    vy         = v.vy;
    wind       = v.w;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    checkVal({tag, " active"}, int'(active), int'(v.act));
    checkVal({tag, " x_pos"}, int'(x_pos), v.x);
    checkVal({tag, " y_pos"}, int'(y_pos), v.y);
    checkVal({tag, " done"}, int'(done), int'(v.dn));
    checkVal({tag, " turn"}, int'(turn), int'(v.trn));
    checkVal({tag, " owner"}, int'(owner), int'(v.own));
  endtask

  task automatic tickOnce();
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic idleOnce();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic runFlight(input string tag);
    for (int i = 0; i < 40 && !done; i++) begin
      tickOnce();
    end
    checkVal({tag, " flight ended"}, int'(done), 1);
  endtask

  initial begin
    int yList[9];
    int mx;
    int my;
    int mv;
    yList = '{104, 107, 109, 110, 110, 109, 107, 104, 100};

    vecs[0] = mk(0, 1, 0, 5, 4, 0, 0, 60, 100, 0, 0, 0);
    vecs[1] = mk(1, 0, 0, 5, 4, 0, 1, 60, 100, 0, 0, 0);
    vecs[2] = mk(1, 0, 0, 20, 20, 0, 1, 60, 100, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      vecs[3+i] = mk(1, 0, 1, 0, 0, 0, (i == 8) ? 0 : 1, 65 + 5 * i, yList[i],
                     (i == 8) ? 1 : 0, 0, 0);
    end
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 105, 100, 0, 1, 0);
    vecs[13] = mk(1, 1, 1, 7, 2, 0, 1, 964, 100, 0, 1, 1);
    vecs[14] = mk(0, 0, 1, 0, 0, 0, 1, 957, 102, 0, 1, 1);
    vecs[15] = mk(0, 0, 1, 0, 0, 0, 1, 950, 103, 0, 1, 1);
    vecs[16] = mk(0, 0, 1, 0, 0, 0, 1, 943, 103, 0, 1, 1);
    vecs[17] = mk(0, 0, 1, 0, 0, 0, 1, 936, 102, 0, 1, 1);
    vecs[18] = mk(0, 0, 1, 0, 0, 0, 0, 929, 100, 1, 1, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 929, 100, 0, 0, 1);
    vecs[20] = mk(1, 0, 0, 3, 0, 0, 1, 60, 100, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 0, 0, 0, 63, 100, 1, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 63, 100, 0, 1, 0);
    vecs[23] = mk(0, 1, 0, 63, 63, 0, 1, 964, 100, 0, 1, 1);

    rst        = 1'b1;
    throw_cat  = 1'b0;
    throw_dog  = 1'b0;
    frame_tick = 1'b0;
    vx         = 6'd0;
    vy         = 6'd0;
    wind       = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", mk(0, 0, 0, 0, 0, 0, 0, 60, 100, 0, 0, 0));
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Dog at full speed runs off the left edge on tick 16 while still airborne.
    mx = 964;
    my = 100;
    mv = 63;
    for (int k = 1; k <= 16; k++) begin
      tickOnce();
      mx = mx - 63;
      my = my + mv;
      mv = mv - 1;
      checkOutput($sformatf("offscreen tick%0d", k),
                  mk(0, 0, 0, 0, 0, 0, (k == 16) ? 0 : 1, (mx < 0) ? 0 : mx, my,
                     (k == 16) ? 1 : 0, 1, 1));
    end
    checkVal("offscreen y above ground", int'(y_pos > 12'd100), 1);
    idleOnce();
    checkVal("offscreen turn handed to cat", int'(turn), 0);

    applyStimulus(mk(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    tickOnce();
    checkVal("short cat done", int'(done), 1);
    idleOnce();
    checkVal("short cat turn", int'(turn), 1);

    applyStimulus(mk(0, 1, 0, 5, 4, 0, 0, 0, 0, 0, 0, 0));
    tickOnce();
    tickOnce();
    checkVal("abort pre x_pos", int'(x_pos), 954);
    rst = 1'b1;
    tickOnce();
    rst = 1'b0;
    checkOutput("abort", mk(0, 0, 0, 0, 0, 0, 0, 60, 100, 0, 0, 0));
    idleOnce();
    checkVal("abort no late done", int'(done), 0);
    checkVal("abort stays idle", int'(active), 0);

`ifdef PROJ_WIND_EN
    applyStimulus(mk(1, 0, 0, 5, 4, -2, 0, 0, 0, 0, 0, 0));
    wind = 4'b1110;
    runFlight("wind-2");
    checkVal("wind-2 x_pos", int'(x_pos), 87);
    checkVal("wind-2 y_pos", int'(y_pos), 100);
    idleOnce();
    applyStimulus(mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    runFlight("wind dog");
    idleOnce();
    applyStimulus(mk(1, 0, 0, 5, 4, 3, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 40 && !done; i++) begin
      applyStimulus(mk(0, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    end
    checkVal("wind+3 flight ended", int'(done), 1);
    checkVal("wind+3 x_pos", int'(x_pos), 132);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
